// File: rtl/nibbler_pkg.sv
// Shared definitions for the Nibbler sequencer: opcodes, FSM encoding,
// ALU operation codes and the decoded control word.
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_JC   = 4'h0,
    OP_JNC  = 4'h1,
    OP_CMPI = 4'h2,
    OP_CMPM = 4'h3,
    OP_LIT  = 4'h4,
    OP_IN   = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_JZ   = 4'h8,
    OP_JNZ  = 4'h9,
    OP_ADDI = 4'hA,
    OP_ADDM = 4'hB,
    OP_JMP  = 4'hC,
    OP_OUT  = 4'hD,
    OP_NORI = 4'hE,
    OP_NORM = 4'hF
  } opcode_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_FETCH = 2'd0;
  localparam state_t ST_ADDR  = 2'd1;
  localparam state_t ST_EXEC  = 2'd2;
  localparam state_t ST_HALT  = 2'd3;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_NOR  = 2'd2;
  localparam logic [1:0] ALU_CMP  = 2'd3;

  typedef struct packed {
    logic       load_accu;
    logic       load_flags;
    logic [1:0] alu_op;
    logic       alu_src_mem;
    logic       ram_cs;
    logic       ram_we;
    logic [2:0] in_sel;
    logic [2:0] out_we;
    logic       jump;
  } ctrl_t;

  // Long ops carry a second ROM byte holding the low address bits.
  function automatic logic is_long_op(input logic [3:0] op);
    case (op)
      OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP,
      OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NORM: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Port 3 is unpopulated, so it maps to no strobe at all.
  function automatic logic [2:0] port_onehot(input logic [1:0] port);
    case (port)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/nibbler_decode.sv
// Combinational opcode + flag decoder producing the datapath control word.
// The sequencer qualifies the result with the EXEC state.
module nibbler_decode
  import nibbler_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [1:0] port_sel,
  input  logic       c_flag,
  input  logic       z_flag,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    ctrl        = '0;
    ctrl.alu_op = ALU_PASS;
    case (opcode_e'(opcode))
      OP_JC:  ctrl.jump = c_flag;
      OP_JNC: ctrl.jump = ~c_flag;
      OP_JZ:  ctrl.jump = z_flag;
      OP_JNZ: ctrl.jump = ~z_flag;
      OP_JMP: ctrl.jump = 1'b1;
      OP_LIT: ctrl.load_accu = 1'b1;
      OP_ADDI, OP_ADDM: begin
        ctrl.load_accu  = 1'b1;
        ctrl.load_flags = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_NORI, OP_NORM: begin
        ctrl.load_accu  = 1'b1;
        ctrl.load_flags = 1'b1;
        ctrl.alu_op     = ALU_NOR;
      end
      OP_CMPI, OP_CMPM: begin
        ctrl.load_flags = 1'b1;
        ctrl.alu_op     = ALU_CMP;
      end
      OP_LD: ctrl.load_accu = 1'b1;
      OP_ST: ctrl.ram_we = 1'b1;
      OP_IN: begin
        ctrl.load_accu = 1'b1;
        ctrl.in_sel    = port_onehot(port_sel);
      end
      OP_OUT: ctrl.out_we = port_onehot(port_sel);
      default: ;
    endcase

    // Memory-operand ops share the RAM select and B-operand source.
    case (opcode_e'(opcode))
      OP_ADDM, OP_NORM, OP_CMPM, OP_LD: begin
        ctrl.alu_src_mem = 1'b1;
        ctrl.ram_cs      = 1'b1;
      end
      OP_ST:   ctrl.ram_cs = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/nibbler_sequencer.sv
// Fetch/decode/execute control unit for the 4-bit Nibbler core, with
// run/halt/single-step debug control.
module nibbler_sequencer
  import nibbler_pkg::*;
#(
  parameter int              PC_W          = 12,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter bit              START_RUNNING = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      program_byte,
  input  logic            c_flag,
  input  logic            z_flag,
  input  logic            run,
  input  logic            step,
  output logic [PC_W-1:0] pc,
  output logic            phase,
  output logic [3:0]      instr,
  output logic [3:0]      operand,
  output logic [PC_W-1:0] ram_addr,
  output logic            load_accu,
  output logic            load_flags,
  output logic [1:0]      alu_op,
  output logic            alu_src_mem,
  output logic            ram_cs,
  output logic            ram_we,
  output logic [2:0]      in_sel,
  output logic [2:0]      out_we,
  output logic            halted
);

  state_t          state;
  logic [7:0]      addr_lo;
  logic            step_credit;
  logic            step_armed;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  ctrl_t           dec_ctrl;
  ctrl_t           exec_ctrl;
  logic            in_exec;

  assign pc_inc  = pc + PC_W'(1);
  assign target  = PC_W'({operand, addr_lo});
  assign in_exec = (state == ST_EXEC);

  nibbler_decode u_decode (
    .opcode   (instr),
    .port_sel (operand[1:0]),
    .c_flag   (c_flag),
    .z_flag   (z_flag),
    .ctrl     (dec_ctrl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= START_RUNNING ? ST_FETCH : ST_HALT;
      pc          <= RESET_PC;
      instr       <= '0;
      operand     <= '0;
      addr_lo     <= '0;
      step_credit <= 1'b0;
      step_armed  <= 1'b1;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees start-of-cycle state.
      if (!step) step_armed <= 1'b1;

      case (state)
        ST_FETCH: begin
          if (!run && !step_credit) begin
            state <= ST_HALT;
          end else begin
            instr       <= program_byte[7:4];
            operand     <= program_byte[3:0];
            pc          <= pc_inc;
            step_credit <= 1'b0;
            state       <= is_long_op(program_byte[7:4]) ? ST_ADDR : ST_EXEC;
          end
        end
        ST_ADDR: begin
          addr_lo <= program_byte;
          pc      <= pc_inc;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec_ctrl.jump) pc <= target;
          state <= ST_FETCH;
        end
        ST_HALT: begin
          // A held step button only counts once; it must be released to re-arm.
          if (step && step_armed) begin
            step_credit <= 1'b1;
            step_armed  <= 1'b0;
            state       <= ST_FETCH;
          end else if (run) begin
            state <= ST_FETCH;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  // Gating is combinational on state, so an async reset drops every strobe at once.
  assign exec_ctrl = in_exec ? dec_ctrl : '0;

  assign load_accu   = exec_ctrl.load_accu;
  assign load_flags  = exec_ctrl.load_flags;
  assign alu_op      = exec_ctrl.alu_op;
  assign alu_src_mem = exec_ctrl.alu_src_mem;
  assign ram_cs      = exec_ctrl.ram_cs;
  assign ram_we      = exec_ctrl.ram_we;
  assign in_sel      = exec_ctrl.in_sel;
  assign out_we      = exec_ctrl.out_we;

  // During ADDR the low byte is still on the ROM bus; forwarding it keeps
  // ram_addr steady from ADDR into EXEC.
  assign ram_addr = (state == ST_ADDR) ? PC_W'({operand, program_byte}) : target;

  assign phase  = in_exec;
  assign halted = (state == ST_HALT);

endmodule
